swim_rx: RTL

Receiver for the SWIM single-wire debug line, the target-to-host counterpart of the SWIM entry/transmit logic. It samples the shared `swim` pin while the local driver is released, measures low-phase pulse widths to decode low-speed SWIM bits, and assembles target frames: header, 8 data bits, parity. Decoded bytes go out on a valid/ready stream matching the USB-UART pipeline in `top`, so they can be forwarded to the host.

---
 rtl/swim_pkg.sv | 25 ++
 rtl/swim_line_sync.sv | 32 +++
 rtl/swim_rx.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/swim_pkg.sv
// Shared SWIM low-speed constants, FSM state encoding and frame bit positions.
// Used by both the receiver and the transmitter.
package swim_pkg;

  localparam int unsigned T_THRESH   = 66;
  localparam int unsigned T_GLITCH   = 3;
  localparam int unsigned T_MAXLOW   = 240;
  localparam int unsigned T_LINERST  = 768;
  localparam int unsigned T_TIMEOUT  = 1024;

  // Phase-length counter must be able to hold T_TIMEOUT itself.
  localparam int unsigned LEN_W      = $clog2(T_TIMEOUT + 1);
  localparam int unsigned CNT_W      = 4;

  localparam logic [CNT_W-1:0] BIT_HDR    = CNT_W'(0);
  localparam logic [CNT_W-1:0] BIT_PARITY = CNT_W'(9);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_DATA_HIGH,
    ST_WAIT_IDLE
  } swim_state_e;

endpackage

// File: rtl/swim_line_sync.sv
// Two-flop synchronizer for the SWIM pad with registered edge pulses that
// line up with the first cycle of the new synchronized level.
module swim_line_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, level_q, rise_q, fall_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q  <= 1'b1;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      meta_q  <= pin_i;
      level_q <= meta_q;
      rise_q  <= meta_q & ~level_q;
      fall_q  <= ~meta_q & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/swim_rx.sv
// SWIM low-speed receiver: measures low-phase widths, decodes target frames
// (header, 8 data bits MSB first, parity) and hands bytes out on valid/ready.
module swim_rx
  import swim_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       swim_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_done,
  output logic       parity_ok,
  output logic       frame_err,
  output logic       line_rst,
  output logic       overrun
);

  logic level, rise, fall;

  swim_line_sync u_sync (
    .clk_i   (clk),
    .rst_ni  (reset),
    .pin_i   (swim_in),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  logic [LEN_W-1:0] len_q, len_d;
  swim_state_e      state_q, prior_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             bit_q, bit_pend_q;
  logic [7:0]       shreg_q, rx_data_q;
  logic             par_q, rx_valid_q, frame_done_q, parity_ok_q;
  logic             frame_err_q, line_rst_q, overrun_q;
  logic             consume_c, hdr_zero_c, parity_end_c;

  // Phase length: restarts on every synchronized edge, saturates at the timeout.
  always_comb begin
    len_d = len_q;
    if (rise || fall) begin
      len_d = '0;
    end else if (len_q != LEN_W'(T_TIMEOUT)) begin
      len_d = len_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) len_q <= '0;
    else        len_q <= len_d;
  end

  assign consume_c    = (state_q == ST_DATA_HIGH) && bit_pend_q;
  assign hdr_zero_c   = consume_c && (bit_cnt_q == BIT_HDR) && !bit_q;
  assign parity_end_c = consume_c && (bit_cnt_q == BIT_PARITY);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      prior_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      bit_q        <= 1'b0;
      bit_pend_q   <= 1'b0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      parity_ok_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      line_rst_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      line_rst_q   <= 1'b0;
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;

      if (!en) begin
        state_q    <= ST_IDLE;
        bit_pend_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (fall) begin
              state_q   <= ST_LOW;
              prior_q   <= ST_IDLE;
              bit_cnt_q <= '0;
              shreg_q   <= '0;
              par_q     <= 1'b0;
            end
          end

          ST_LOW: begin
            if (rise) begin
              if (len_q < LEN_W'(T_GLITCH)) begin
                state_q <= prior_q;
              end else if (len_q > LEN_W'(T_MAXLOW)) begin
                frame_err_q <= 1'b1;
                state_q     <= ST_IDLE;
              end else begin
                bit_q      <= (len_q < LEN_W'(T_THRESH));
                bit_pend_q <= 1'b1;
                state_q    <= ST_DATA_HIGH;
              end
            end else if (len_q == LEN_W'(T_LINERST)) begin
              line_rst_q <= 1'b1;
              state_q    <= ST_WAIT_IDLE;
            end
          end

          ST_DATA_HIGH: begin
            bit_pend_q <= 1'b0;
            if (hdr_zero_c) begin
              // Host frame echo on the shared line: not ours to decode.
              state_q <= ST_WAIT_IDLE;
            end else if (parity_end_c) begin
              frame_done_q <= 1'b1;
              parity_ok_q  <= (par_q == bit_q);
              if (!rx_valid_q || rx_ready) begin
                rx_data_q  <= shreg_q;
                rx_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
              state_q <= ST_IDLE;
            end else begin
              if (consume_c) begin
                if (bit_cnt_q != BIT_HDR) begin
                  shreg_q <= {shreg_q[6:0], bit_q};
                  par_q   <= par_q ^ bit_q;
                end
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              end
              if (fall) begin
                prior_q <= ST_DATA_HIGH;
                state_q <= ST_LOW;
              end else if (len_q == LEN_W'(T_TIMEOUT)) begin
                frame_err_q <= 1'b1;
                state_q     <= ST_IDLE;
              end
            end
          end

          ST_WAIT_IDLE: begin
            if (level && (len_q == LEN_W'(T_TIMEOUT))) state_q <= ST_IDLE;
          end

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_done = frame_done_q;
  assign parity_ok  = parity_ok_q;
  assign frame_err  = frame_err_q;
  assign line_rst   = line_rst_q;
  assign overrun    = overrun_q;

endmodule
